// File: rtl/step_pulse_gen_pkg.sv
// Shared definitions for the step/direction pulse generator:
// FSM state encoding, effective-period width and parameter sanity check.
package step_pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DSETUP = 2'd1,
    ST_HIGH   = 2'd2,
    ST_LOW    = 2'd3
  } state_e;

  // Width of per_q*PRESCALE with no truncation, widened if MIN_PERIOD needs more.
  function automatic int eff_width(input int width_work, input int prescale,
                                   input int min_period);
    int w_scaled;
    int w_min;
    w_scaled = width_work + $clog2(prescale);
    w_min    = $clog2(min_period + 1);
    return (w_scaled > w_min) ? w_scaled : w_min;
  endfunction

  // The LOW phase must be at least as long as the HIGH phase.
  function automatic bit timing_ok(input int min_period, input int pulse_w);
    return min_period >= 2 * pulse_w;
  endfunction

endpackage

// File: rtl/step_pulse_gen_if.sv
// Command and driver-side signals of the step pulse generator.
// master = regulator/bench side, slave = step_pulse_gen.
interface step_pulse_gen_if #(
  parameter int WIDTH_WORK = 16,
  parameter int POS_W      = 32
);
  logic                  enable;
  logic                  dir_in;
  logic [WIDTH_WORK-1:0] period;
  logic                  pos_clr;
  logic                  drv_step;
  logic                  drv_dir;
  logic                  busy;
  logic [POS_W-1:0]      position;  // two's-complement step count

  modport master (
    output enable, dir_in, period, pos_clr,
    input  drv_step, drv_dir, busy, position
  );

  modport slave (
    input  enable, dir_in, period, pos_clr,
    output drv_step, drv_dir, busy, position
  );
endinterface

// File: rtl/step_pulse_gen_period_sync.sv
// Two-sample stability capture of the period word coming from the
// data_valid domain: a value is accepted only when seen on two consecutive clocks.
module period_sync #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] per_q
);

  logic [WIDTH-1:0] cand;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand  <= '0;
      per_q <= '0;
    end else begin
      cand <= period;
      if (period == cand) per_q <= period;
    end
  end

endmodule

// File: rtl/step_pulse_gen.sv
// Step/direction pulse generator: enforces step pulse width, direction setup
// and minimum spacing, and keeps a signed position count of issued steps.
module step_pulse_gen
  import step_pulse_gen_pkg::*;
#(
  parameter int WIDTH_WORK = 16,
  parameter int PRESCALE   = 8,
  parameter int PULSE_W    = 100,
  parameter int DIR_SETUP  = 250,
  parameter int MIN_PERIOD = 200,
  parameter int POS_W      = 32
) (
  input logic               clk,
  input logic               rst_n,
  step_pulse_gen_if.slave   bus
);

  localparam int EFF_W   = eff_width(WIDTH_WORK, PRESCALE, MIN_PERIOD);
  localparam int SETUP_W = $clog2(DIR_SETUP + 1);
  localparam int CNT_W   = (EFF_W > SETUP_W) ? EFF_W : SETUP_W;

  if (!timing_ok(MIN_PERIOD, PULSE_W)) begin : g_bad_timing
    $error("step_pulse_gen: MIN_PERIOD must be at least 2*PULSE_W");
  end

  logic [WIDTH_WORK-1:0] per_q;
  logic [EFF_W-1:0]      scaled;
  logic [EFF_W-1:0]      eff_now;
  logic [EFF_W-1:0]      eff_q;
  state_e                state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic                  dir_q, dir_next;
  logic                  step_entry;
  logic                  step_q;
  logic                  busy_q;
  logic [POS_W-1:0]      pos_q;

  period_sync #(.WIDTH(WIDTH_WORK)) u_period_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .period (bus.period),
    .per_q  (per_q)
  );

  assign scaled  = EFF_W'(per_q) * EFF_W'(PRESCALE);
  assign eff_now = (scaled < EFF_W'(MIN_PERIOD)) ? EFF_W'(MIN_PERIOD) : scaled;

  // Each phase loads its length minus one and leaves when the counter hits zero.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    dir_next   = dir_q;
    case (state)
      ST_IDLE: begin
        cnt_next = '0;
        if (bus.enable && per_q != '0) begin
          state_next = ST_DSETUP;
          cnt_next   = CNT_W'(DIR_SETUP - 1);
          dir_next   = bus.dir_in;
        end
      end
      ST_DSETUP: begin
        if (!bus.enable) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt == '0) begin
          state_next = ST_HIGH;
          cnt_next   = CNT_W'(PULSE_W - 1);
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      ST_HIGH: begin
        // The pulse always runs to completion, whatever enable or dir_in do.
        if (cnt == '0) begin
          state_next = ST_LOW;
          cnt_next   = CNT_W'(eff_q) - CNT_W'(PULSE_W + 1);
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      ST_LOW: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else if (!bus.enable || per_q == '0) begin
          state_next = ST_IDLE;
        end else if (bus.dir_in != dir_q) begin
          state_next = ST_DSETUP;
          cnt_next   = CNT_W'(DIR_SETUP - 1);
          dir_next   = bus.dir_in;
        end else begin
          state_next = ST_HIGH;
          cnt_next   = CNT_W'(PULSE_W - 1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign step_entry = (state_next == ST_HIGH) && (state != ST_HIGH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      dir_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      dir_q <= dir_next;
    end
  end

  // Outputs are registered from the next state so they switch with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eff_q  <= '0;
      step_q <= 1'b0;
      busy_q <= 1'b0;
      pos_q  <= '0;
    end else begin
      step_q <= (state_next == ST_HIGH);
      busy_q <= (state_next != ST_IDLE);
      if (step_entry) eff_q <= eff_now;
      if (bus.pos_clr) begin
        pos_q <= '0;
      end else if (step_entry) begin
        pos_q <= dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
      end
    end
  end

  assign bus.drv_step = step_q;
  assign bus.drv_dir  = dir_q;
  assign bus.busy     = busy_q;
  assign bus.position = pos_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Scoreboard bench for step_pulse_gen: stimulus predicts each step rise
// (cycle, direction, position) from period arithmetic; a monitor checks them.
module tb_step_pulse_gen;

  localparam int WIDTH_WORK = 16;
  localparam int PRESCALE   = 1;
  localparam int PULSE_W    = 4;
  localparam int DIR_SETUP  = 8;
  localparam int MIN_PERIOD = 8;
  localparam int POS_W      = 16;

  typedef struct {
    int               t;
    bit               dir;
    logic [POS_W-1:0] pos;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  exp_t             exp_q[$];
  exp_t             mon_e;
  logic [POS_W-1:0] pos_m;
  bit               step_prev;
  int               hi_len;

  step_pulse_gen_if #(.WIDTH_WORK(WIDTH_WORK), .POS_W(POS_W)) bus ();

  step_pulse_gen #(
    .WIDTH_WORK (WIDTH_WORK),
    .PRESCALE   (PRESCALE),
    .PULSE_W    (PULSE_W),
    .DIR_SETUP  (DIR_SETUP),
    .MIN_PERIOD (MIN_PERIOD),
    .POS_W      (POS_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Returns #1 after posedge number t.
  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops one expectation per drv_step rising edge, measures pulse width.
  always @(negedge clk) begin
    if (!rst_n) begin
      step_prev = 1'b0;
      hi_len    = 0;
    end else begin
      if (bus.drv_step && !step_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_step: rise at cycle %0d with no expectation", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("rise_cycle", cyc, mon_e.t);
          check("rise_dir", 32'(bus.drv_dir), 32'(mon_e.dir));
          check("rise_position", 32'(bus.position), 32'(mon_e.pos));
        end
        hi_len = 0;
      end
      if (bus.drv_step) hi_len++;
      if (!bus.drv_step && step_prev) check("pulse_width", hi_len, PULSE_W);
      step_prev = bus.drv_step;
    end
  end

  // One burst of n steps at period p; enable drops one cycle into the last pulse.
  // rev_mode: 0 keep direction, 1 random, 2 toggle every step (changed mid-LOW).
  // clr_mode: 0 none, 1 random, 2 pos_clr on the first step.
  task automatic run_trial(input int p, input bit d0, input int n, input int rev_mode,
                           input int clr_mode, input bit glitch);
    int eff, r, rc;
    bit d, nd, clr;
    eff = (p * PRESCALE < MIN_PERIOD) ? MIN_PERIOD : p * PRESCALE;
    bus.period = WIDTH_WORK'(p);
    bus.dir_in = d0;
    wait_until(cyc + 3);
    bus.enable = 1'b1;
    r = cyc + 1 + DIR_SETUP;
    d = d0;
    rc = r;
    for (int i = 0; i < n; i++) begin
      rc  = r;
      clr = (clr_mode == 2 && i == 0) || (clr_mode == 1 && $urandom_range(0, 2) == 0);
      if (clr) pos_m = '0;
      else     pos_m = d ? pos_m + POS_W'(1) : pos_m - POS_W'(1);
      exp_q.push_back('{t: rc, dir: d, pos: pos_m});
      wait_until(rc - 1);
      bus.pos_clr = clr;
      wait_until(rc);
      bus.pos_clr = 1'b0;
      wait_until(rc + 1);
      if (glitch) bus.period = WIDTH_WORK'(p + 7);
      if (i == n - 1) bus.enable = 1'b0;
      wait_until(rc + 2);
      bus.period = WIDTH_WORK'(p);
      if (i != n - 1) begin
        case (rev_mode)
          1:       nd = 1'($urandom_range(0, 1));
          2:       nd = ~d;
          default: nd = d;
        endcase
        wait_until(rc + PULSE_W + 1);
        bus.dir_in = nd;
        r = rc + eff + ((nd != d) ? DIR_SETUP : 0);
        d = nd;
      end
    end
    wait_until(rc + eff - 1);
    check("busy_before_idle", 32'(bus.busy), 32'd1);
    wait_until(rc + eff);
    check("busy_after_idle", 32'(bus.busy), 32'd0);
    check("step_low_idle", 32'(bus.drv_step), 32'd0);
  endtask

  initial begin
    int r;
    checks       = 0;
    errors       = 0;
    pos_m        = '0;
    rst_n        = 1'b0;
    bus.enable   = 1'b0;
    bus.dir_in   = 1'b0;
    bus.period   = '0;
    bus.pos_clr  = 1'b0;

    wait_until(3);
    check("reset_step", 32'(bus.drv_step), 32'd0);
    check("reset_dir", 32'(bus.drv_dir), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_position", 32'(bus.position), 32'd0);
    rst_n = 1'b1;
    wait_until(cyc + 2);

    // Directed: nominal, clamped, reversal, single step, glitch.
    run_trial(20, 1'b1, 3, 0, 0, 1'b0);
    check("position_after_3", 32'(bus.position), 32'd3);
    run_trial(3, 1'b1, 3, 0, 0, 1'b0);
    run_trial(20, 1'b1, 3, 2, 0, 1'b0);
    run_trial(20, 1'b0, 1, 0, 0, 1'b0);
    run_trial(20, 1'b1, 3, 0, 0, 1'b1);

    // period 0 holds the generator idle even with enable high.
    bus.period = '0;
    wait_until(cyc + 3);
    bus.enable = 1'b1;
    wait_until(cyc + 15);
    check("period_zero_idle", 32'(bus.busy), 32'd0);
    bus.enable = 1'b0;
    wait_until(cyc + 2);

    // Randomized bursts.
    for (int k = 0; k < 12; k++) begin
      run_trial($urandom_range(1, 25), 1'($urandom_range(0, 1)), $urandom_range(1, 4),
                1, 1, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a pulse.
    bus.period = 16'd20;
    bus.dir_in = 1'b1;
    wait_until(cyc + 3);
    bus.enable = 1'b1;
    r = cyc + 1 + DIR_SETUP;
    pos_m = pos_m + POS_W'(1);
    exp_q.push_back('{t: r, dir: 1'b1, pos: pos_m});
    wait_until(r + 1);
    bus.enable = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midpulse_reset_step", 32'(bus.drv_step), 32'd0);
    check("midpulse_reset_busy", 32'(bus.busy), 32'd0);
    check("midpulse_reset_position", 32'(bus.position), 32'd0);
    pos_m = '0;
    wait_until(cyc + 3);
    rst_n = 1'b1;
    wait_until(cyc + 2);

    // pos_clr coinciding with the first step after reset wins over the step.
    run_trial(20, 1'b1, 1, 0, 2, 1'b0);
    check("clr_wins_position", 32'(bus.position), 32'd0);

    wait_until(cyc + 5);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
